// File: rtl/adder_sweep_checker_if.sv
// Adder datapath interface: operands out to a combinational adder, result back.
// The checker is the receiving end (slave) and drives the operands; the adder
// under test takes the master side and returns {carry, sum}.
interface adder_sweep_checker_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_c;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_carry;

    modport master (
        input  dut_a,
        input  dut_b,
        input  dut_c,
        output dut_sum,
        output dut_carry
    );

    modport slave (
        output dut_a,
        output dut_b,
        output dut_c,
        input  dut_sum,
        input  dut_carry
    );
endinterface

// File: rtl/adder_sweep_checker.sv
// Exhaustive BIST sweep for a combinational adder: drives every {a,b,c}
// vector, waits SETTLE cycles, samples {carry,sum} and compares it against a+b+c.
// Tracks the mismatch count and the lowest failing vector index.
module adder_sweep_checker #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    adder_sweep_checker_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail,
    output logic                 fail_seen
);
    localparam int unsigned IDXW = 2*WIDTH + 1;
    localparam int unsigned ERRW = 2*WIDTH + 2;
    localparam int unsigned SUMW = WIDTH + 1;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic [IDXW-1:0]  first_q, first_d;
    logic             seen_q, seen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic [SUMW-1:0]  expected;
    logic             mismatch;

    // Vector index maps straight onto the operands: a in the MSBs, c in the LSB.
    assign op_a = idx_q[WIDTH+1 +: WIDTH];
    assign op_b = idx_q[1 +: WIDTH];
    assign op_c = idx_q[0];

    assign bus.dut_a = op_a;
    assign bus.dut_b = op_b;
    assign bus.dut_c = op_c;

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = done_q && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = first_q;
    assign fail_seen  = seen_q;

    // Reference sum and compare against the returned adder result.
    always_comb begin
        expected = SUMW'(op_a) + SUMW'(op_b) + SUMW'(op_c);
        mismatch = ({bus.dut_carry, bus.dut_sum} != expected);
    end

    // Next-state logic: settle/sample sequencing and result bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        seen_d  = seen_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    seen_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERRW'(1);
                    if (!seen_q) begin
                        first_d = idx_q;
                        seen_d  = 1'b1;
                    end
                end
                if (idx_q == '1) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker: a default instance driven by an adder
// model with selectable faults, and a SETTLE=1 instance with an ideal adder.
module tb_adder_sweep_checker;
    logic clk;
    logic rst_n0, start0, rst_n1, start1;
    int   mode0;

    logic       busy0, done0, pass0, seen0;
    logic [5:0] err0;
    logic [4:0] ff0;
    logic       busy1, done1, pass1, seen1;
    logic [5:0] err1;
    logic [4:0] ff1;

    int n_checks = 0;
    int n_errors = 0;

    adder_sweep_checker_if #(.WIDTH(2)) bus0 ();
    adder_sweep_checker_if #(.WIDTH(2)) bus1 ();

    adder_sweep_checker #(.WIDTH(2), .SETTLE(4)) dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .fail_seen(seen0)
    );

    adder_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1), .fail_seen(seen1)
    );

    // Adder under test; mode 1 = carry stuck at 0, mode 2 = sum[0] inverted.
    function automatic logic [2:0] adder_model(input logic [1:0] a, input logic [1:0] b,
                                               input logic c, input int mode);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b} + {2'b00, c};
        if (mode == 1) s[2] = 1'b0;
        if (mode == 2) s[0] = ~s[0];
        return s;
    endfunction

    assign {bus0.dut_carry, bus0.dut_sum} = adder_model(bus0.dut_a, bus0.dut_b, bus0.dut_c, mode0);
    assign {bus1.dut_carry, bus1.dut_sum} = adder_model(bus1.dut_a, bus1.dut_b, bus1.dut_c, 0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 0;
        adv(2);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_ff", 32'(ff0), 0);
        check("rst_seen", 32'(seen0), 0);
        check("rst_ops", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 0);
        check("rst1_done", 32'(done1), 0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        adv(1);

        // 1: ideal adder, full sweep and operand timing
        pulse_start0();
        check("t1_busy0", 32'(busy0), 1);
        check("t1_ops_e0", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 0);
        adv(4);
        check("t1_ops_e4", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 0);
        adv(1);
        check("t1_ops_e5", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 1);
        adv(5);
        check("t1_ops_e10", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 2);
        adv(149);
        check("t1_done_e159", 32'(done0), 0);
        check("t1_busy_e159", 32'(busy0), 1);
        adv(1);
        check("t1_done", 32'(done0), 1);
        check("t1_busy", 32'(busy0), 0);
        check("t1_pass", 32'(pass0), 1);
        check("t1_err", 32'(err0), 0);
        check("t1_ff", 32'(ff0), 0);
        check("t1_seen", 32'(seen0), 0);
        adv(10);
        check("t1_done_hold", 32'(done0), 1);

        // 2: carry stuck at 0, restarted from DONE
        mode0 = 1;
        pulse_start0();
        check("t2_done_clr", 32'(done0), 0);
        adv(159);
        check("t2_done_e159", 32'(done0), 0);
        adv(1);
        check("t2_done", 32'(done0), 1);
        check("t2_err", 32'(err0), 16);
        check("t2_ff", 32'(ff0), 7);
        check("t2_pass", 32'(pass0), 0);
        check("t2_seen", 32'(seen0), 1);

        // 6: start in DONE clears results in the same cycle
        mode0 = 0;
        pulse_start0();
        check("t6_done_clr", 32'(done0), 0);
        check("t6_err_clr", 32'(err0), 0);
        check("t6_seen_clr", 32'(seen0), 0);
        check("t6_ff_clr", 32'(ff0), 0);
        check("t6_busy", 32'(busy0), 1);
        adv(159);
        check("t6_done_e159", 32'(done0), 0);
        adv(1);
        check("t6_done", 32'(done0), 1);
        check("t6_pass", 32'(pass0), 1);

        // 3: sum[0] inverted, every vector fails
        mode0 = 2;
        pulse_start0();
        adv(160);
        check("t3_done", 32'(done0), 1);
        check("t3_err", 32'(err0), 32);
        check("t3_ff", 32'(ff0), 0);
        check("t3_seen", 32'(seen0), 1);
        check("t3_pass", 32'(pass0), 0);

        // 4: reset mid-sweep at edge 50
        pulse_start0();
        adv(49);
        check("t4_err_e49", 32'(err0), 9);
        check("t4_seen_e49", 32'(seen0), 1);
        rst_n0 = 1'b0;
        step();
        rst_n0 = 1'b1;
        check("t4_busy", 32'(busy0), 0);
        check("t4_done", 32'(done0), 0);
        check("t4_err", 32'(err0), 0);
        check("t4_seen", 32'(seen0), 0);
        check("t4_ff", 32'(ff0), 0);
        check("t4_ops", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 0);
        adv(3);
        check("t4_idle_busy", 32'(busy0), 0);
        check("t4_idle_done", 32'(done0), 0);
        mode0 = 0;
        pulse_start0();
        adv(159);
        check("t4_done_e159", 32'(done0), 0);
        adv(1);
        check("t4_redone", 32'(done0), 1);
        check("t4_pass", 32'(pass0), 1);

        // 5: extra start pulses at edges 20 and 100 are ignored
        mode0 = 1;
        pulse_start0();
        adv(19);
        pulse_start0();
        check("t5_ops_e20", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 4);
        check("t5_busy_e20", 32'(busy0), 1);
        adv(79);
        pulse_start0();
        check("t5_ops_e100", 32'({bus0.dut_a, bus0.dut_b, bus0.dut_c}), 20);
        adv(59);
        check("t5_done_e159", 32'(done0), 0);
        adv(1);
        check("t5_done", 32'(done0), 1);
        check("t5_err", 32'(err0), 16);
        check("t5_ff", 32'(ff0), 7);

        // 6b: SETTLE=1 sweep takes 64 cycles, twice
        for (int r = 0; r < 2; r++) begin
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("s1_done_clr", 32'(done1), 0);
            adv(63);
            check("s1_done_e63", 32'(done1), 0);
            adv(1);
            check("s1_done", 32'(done1), 1);
            check("s1_pass", 32'(pass1), 1);
            check("s1_err", 32'(err1), 0);
            check("s1_seen", 32'(seen1), 0);
            check("s1_ff", 32'(ff1), 0);
            check("s1_busy", 32'(busy1), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
